// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and error bit indices for the frame receiver
package uart_pkg;

    // Start-of-frame marker
    localparam logic [7:0] SOF = 8'hA5;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    // Bit positions inside the err output
    localparam int ERR_CHK     = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVERRUN = 3;

endpackage

// File: rtl/uart_idle_timer.sv
// rtl/uart_idle_timer.sv - idle-cycle counter that flags a stalled partial frame
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   clear   - restart counting (a byte arrived)
//   enable  - count only while a frame is being parsed
//   expired - high in the cycle the count sits at TIMEOUT-1 with no clear
module uart_idle_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Held at zero while disabled so every entry into a parsing state starts fresh;
    // saturates at LAST because the FSM leaves the counting states on expiry.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A byte in the same cycle wins over the timeout
    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - SOF/LEN/payload/CHK frame parser with buffered payload emit
//
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   in_valid, in_data  - one-cycle byte strobe from the UART receiver, no backpressure
//   out_valid, out_ready, out_data, out_last - payload byte stream to the consumer
//   frame_ok           - one-cycle pulse when a frame's checksum matched
//   err                - one-cycle pulses {overrun, timeout, len, chk}
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic [3:0] err
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      buffer [MAX_LEN];
    logic [IW-1:0]   wr_idx_q;
    logic [IW-1:0]   rd_idx_q;
    logic [IW-1:0]   last_q;
    logic [7:0]      sum_q;
    logic            frame_ok_q;
    logic [3:0]      err_q;
    logic            ok_d;
    logic [3:0]      err_d;
    logic            timer_en;
    logic            expired;
    logic            len_ok;

    assign len_ok   = (in_data != 8'd0) && (in_data <= 8'(MAX_LEN));
    assign timer_en = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    uart_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (in_valid),
        .enable  (timer_en),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the pulse requests that get registered one cycle later
    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 4'd0;
        case (state_q)
            ST_HUNT: begin
                if (in_valid && in_data == SOF) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (expired) begin
                    state_d            = ST_HUNT;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else if (in_valid) begin
                    if (len_ok) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d        = ST_HUNT;
                        err_d[ERR_LEN] = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (expired) begin
                    state_d            = ST_HUNT;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else if (in_valid && wr_idx_q == last_q) begin
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (expired) begin
                    state_d            = ST_HUNT;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else if (in_valid) begin
                    if (in_data == sum_q) begin
                        state_d = ST_EMIT;
                        ok_d    = 1'b1;
                    end else begin
                        state_d        = ST_HUNT;
                        err_d[ERR_CHK] = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                // Incoming bytes cannot be stored while the buffer drains
                if (in_valid) begin
                    err_d[ERR_OVERRUN] = 1'b1;
                end
                if (out_ready && rd_idx_q == last_q) begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Stream outputs; rd_idx and buffer are frozen in EMIT so data holds under backpressure
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        if (state_q == ST_EMIT) begin
            out_valid = 1'b1;
            out_data  = buffer[rd_idx_q];
            out_last  = (rd_idx_q == last_q);
        end
    end

    // Indices, checksum and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            last_q     <= '0;
            sum_q      <= 8'd0;
            frame_ok_q <= 1'b0;
            err_q      <= 4'd0;
        end else begin
            frame_ok_q <= ok_d;
            err_q      <= err_d;
            case (state_q)
                ST_LEN: begin
                    if (in_valid && len_ok) begin
                        sum_q    <= in_data;
                        last_q   <= IW'(in_data - 8'd1);
                        wr_idx_q <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid) begin
                        wr_idx_q <= wr_idx_q + 1'b1;
                        sum_q    <= sum_q + in_data;
                    end
                end
                ST_CHK: begin
                    rd_idx_q <= '0;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        rd_idx_q <= (rd_idx_q == last_q) ? '0 : rd_idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Payload storage keeps its contents across reset
    always_ff @(posedge clk) begin
        if (state_q == ST_PAYLOAD && in_valid) begin
            buffer[wr_idx_q] <= in_data;
        end
    end

    assign frame_ok = frame_ok_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ok;
    logic [3:0] err;

    uart_frame_rx #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int last_cyc = 0;

    typedef struct {
        logic [4:0] pat;
        int         at;
    } evt_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         at;
    } dat_t;

    evt_t       evt_q[$];
    dat_t       dat_q[$];
    logic [7:0] frame_q[$];
    evt_t       me;
    dat_t       md;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_evt(input logic [4:0] pat, input int at);
        evt_q.push_back('{pat: pat, at: at});
    endtask

    task automatic push_dat(input logic [7:0] d, input logic l, input int at);
        dat_q.push_back('{data: d, last: l, at: at});
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends frame_q as a complete frame with a correctly computed checksum
    task automatic send_frame(input bit timed);
        logic [7:0] chk;
        int         n;
        n   = frame_q.size();
        chk = 8'(n);
        send(8'hA5);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            chk = chk + frame_q[i];
            send(frame_q[i]);
        end
        send(chk);
        push_evt(5'b10000, last_cyc);
        for (int i = 0; i < n; i++) begin
            push_dat(frame_q[i], (i == n - 1), timed ? last_cyc + i : -1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " out_data"},  {24'd0, out_data},  32'd0);
        check({tag, " out_last"},  {31'd0, out_last},  32'd0);
        check({tag, " frame_ok"},  {31'd0, frame_ok},  32'd0);
        check({tag, " err"},       {28'd0, err},       32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse or a transfer
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'd0;
    logic       pl = 1'b0;

    always @(negedge clk) begin
        if (frame_ok || err != 4'd0) begin
            n_vec++;
            if (evt_q.size() == 0) begin
                n_bad++;
                $display("FAIL evt: unexpected frame_ok=%0b err=%b at cycle %0d", frame_ok, err, cyc);
            end else begin
                me = evt_q.pop_front();
                if ({frame_ok, err} !== me.pat || (me.at >= 0 && me.at != cyc)) begin
                    n_bad++;
                    $display("FAIL evt: got {ok,err}=%b at cycle %0d expected %b at cycle %0d",
                             {frame_ok, err}, cyc, me.pat, me.at);
                end
            end
        end
        if (out_valid && out_ready) begin
            n_vec++;
            if (dat_q.size() == 0) begin
                n_bad++;
                $display("FAIL dat: unexpected transfer %02h last=%0b at cycle %0d", out_data, out_last, cyc);
            end else begin
                md = dat_q.pop_front();
                if (out_data !== md.data || out_last !== md.last || (md.at >= 0 && md.at != cyc)) begin
                    n_bad++;
                    $display("FAIL dat: got %02h last=%0b at cycle %0d expected %02h last=%0b at cycle %0d",
                             out_data, out_last, cyc, md.data, md.last, md.at);
                end
            end
        end
        if (pv && !pr && !rst) begin
            n_vec++;
            if (!out_valid || out_data !== pd || out_last !== pl) begin
                n_bad++;
                $display("FAIL hold: got valid=%0b data=%02h last=%0b expected valid=1 data=%02h last=%0b",
                         out_valid, out_data, out_last, pd, pl);
            end
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
        pl = out_last;
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        idle(2);
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(2);

        // Good frame, timed delivery
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        push_evt(5'b10000, last_cyc);
        push_dat(8'h11, 1'b0, last_cyc);
        push_dat(8'h22, 1'b0, last_cyc + 1);
        push_dat(8'h33, 1'b1, last_cyc + 2);
        idle(6);

        // Bad checksum, then a good frame
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
        push_evt(5'b00001, last_cyc);
        idle(4);
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b1);
        idle(8);

        // Garbage, then length errors
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h00);
        push_evt(5'b00010, last_cyc);
        idle(3);
        send(8'hA5); send(8'h11);
        push_evt(5'b00010, last_cyc);
        idle(3);

        // Length boundaries 1 and MAX_LEN
        frame_q = '{8'h7F};
        send_frame(1'b1);
        idle(4);
        frame_q = {};
        for (int i = 1; i <= MAX_LEN; i++) frame_q.push_back(8'(i));
        send_frame(1'b1);
        idle(MAX_LEN + 4);

        // Timeout after a partial frame
        send(8'hA5); send(8'h02); send(8'h11);
        push_evt(5'b00100, last_cyc + TIMEOUT);
        idle(TIMEOUT + 4);

        // Byte on the last idle cycle suppresses the timeout
        send(8'hA5); send(8'h02); send(8'h11);
        begin
            int s;
            s = last_cyc;
            repeat (TIMEOUT - 1) @(posedge clk);
            #1;
            send(8'h22);
            check("late byte cycle", last_cyc, s + TIMEOUT);
        end
        send(8'h35);
        push_evt(5'b10000, last_cyc);
        push_dat(8'h11, 1'b0, last_cyc);
        push_dat(8'h22, 1'b1, last_cyc + 1);
        idle(6);

        // Backpressure with an overrun byte during EMIT
        out_ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        push_evt(5'b10000, last_cyc);
        push_dat(8'h11, 1'b0, -1);
        push_dat(8'h22, 1'b0, -1);
        push_dat(8'h33, 1'b1, -1);
        idle(5);
        send(8'h55);
        push_evt(5'b01000, last_cyc);
        idle(12);
        check("bp out_valid", {31'd0, out_valid}, 32'd1);
        check("bp out_data",  {24'd0, out_data},  32'h11);
        check("bp out_last",  {31'd0, out_last},  32'd0);
        out_ready = 1'b1;
        idle(6);

        // Reset mid-payload abandons the frame silently
        send(8'hA5); send(8'h04); send(8'hAA);
        rst = 1'b1;
        idle(1);
        check_outputs_zero("mid reset");
        rst = 1'b0;
        idle(3);
        frame_q = '{8'hDE, 8'hAD};
        send_frame(1'b1);
        idle(6);

        check("evt queue drained", evt_q.size(), 32'd0);
        check("dat queue drained", dat_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter TIMEOUT, default 4096: clk cycles without an input byte before a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: one-cycle byte strobe from the UART receiver; no backpressure.
REQ-006 SHALL have port in_data, input, 8: received byte, qualified by in_valid.
REQ-007 SHALL have port out_valid, output, 1: payload byte available.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts the byte when out_valid and out_ready are both high.
REQ-009 SHALL have port out_data, output, 8: payload byte.
REQ-010 SHALL have port out_last, output, 1: marks the final payload byte of a frame.
REQ-011 SHALL have port frame_ok, output, 1: one-cycle pulse, valid frame received.
REQ-012 SHALL have port err, output, 4: one-cycle pulses {overrun, timeout, len, chk} on bits [3:0].

Function
REQ-013 Frame format SHALL be: SOF 0xA5, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload) mod 256.
REQ-014 States SHALL be HUNT, LEN, PAYLOAD, CHK and EMIT.
REQ-015 HUNT: SOF -> LEN; any other byte is discarded silently.
REQ-016 LEN: LEN in 1..MAX_LEN -> store the length and go to PAYLOAD; LEN 0 or LEN > MAX_LEN -> pulse err[1] and go to HUNT.
REQ-017 PAYLOAD: each byte is written to buffer[wr_idx] and wr_idx increments; the byte with wr_idx==LEN-1 moves the FSM to CHK.
REQ-018 Running checksum: an 8-bit register, wrap-around addition, seeded with LEN.
REQ-019 CHK: a match pulses frame_ok and moves to EMIT; a mismatch pulses err[0] and moves to HUNT.
REQ-020 frame_ok and all err bits SHALL assert in the cycle after the causing byte's in_valid (or timeout) and last exactly one cycle.
REQ-021 EMIT: out_valid=1 from the first EMIT cycle; out_data=buffer[rd_idx]; out_last=(rd_idx==LEN-1).
REQ-022 EMIT handshake: rd_idx advances on a transfer; the transfer of the last byte returns the FSM to HUNT.
REQ-023 While out_ready is low, out_data and out_last SHALL hold stable.
REQ-024 Any in_valid during EMIT: the byte is dropped and err[3] pulses; the FSM is unaffected.
REQ-025 Idle counter in LEN/PAYLOAD/CHK:
- clears on in_valid and on entry to LEN;
- if it reaches TIMEOUT-1 with in_valid low, err[2] pulses and the FSM goes to HUNT;
- in_valid in that same cycle wins, so no timeout fires.
REQ-026 The idle counter SHALL not run in HUNT or EMIT.
REQ-027 Minimum latency: first out_valid one cycle after the CHK byte's in_valid.

Reset
REQ-028 rst SHALL force HUNT and clear wr_idx, rd_idx, the checksum and the idle counter.
REQ-029 rst SHALL drive out_valid, out_last, frame_ok and err to 0, and out_data to 0x00.
REQ-030 rst SHALL NOT clear the payload buffer.
REQ-031 rst asserted mid-frame or mid-EMIT SHALL abandon the frame with no error pulse.

Structure
REQ-032 Package uart_pkg SHALL hold the SOF constant (0xA5), the state encodings and the err bit indices.
REQ-033 One sub-module, uart_idle_timer (parameter TIMEOUT; inputs clk, rst, clear, enable; output expired pulse), SHALL implement REQ-025.
REQ-034 The payload buffer SHALL be a MAX_LEN x 8 register array with no RAM macro; the design is 120-400 lines of RTL.

Verification
REQ-035 Good frame: bytes A5 03 11 22 33 69 with out_ready=1 -> frame_ok once; out_data 11,22,33 on three consecutive cycles; out_last only with 33.
REQ-036 Bad checksum: A5 03 11 22 33 68 -> err[0] pulse, no out_valid; a following good frame is delivered normally.
REQ-037 Length errors: A5 00 and, separately, A5 11 (17 > MAX_LEN) -> err[1] pulse each time, FSM back in HUNT; garbage bytes 00 FF before A5 are ignored.
REQ-038 Timeout: A5 02 11 then silence -> err[2] pulses exactly TIMEOUT cycles after the 11 strobe; a byte arriving on cycle TIMEOUT-1 suppresses the timeout.
REQ-039 Backpressure/overrun: good frame, out_ready=0 for 20 cycles with one in_valid 0x55 during EMIT -> err[3] pulse; out_data held at 11; all 3 bytes delivered after out_ready=1.
REQ-040 Reset mid-PAYLOAD (after A5 04 AA) -> all outputs 0 next cycle, no err; a subsequent good frame parses correctly.
